cfu_arbiter: RTL and testbench
==============================

# cfu_arbiter

Round-robin arbiter that shares one custom-function unit (such as the SHA-256 sigma-0 unit) among NUM_REQ requesters. Requests are forwarded to the unit over a single cfu_interface. An in-order owner FIFO records which requester issued each outstanding request, and each response is routed back to that requester. It sits between the issue-side CFU ports and a single cfu_interface slave unit.

## Interface
- NUM_REQ, 2: number of requester ports; 2..8.
- MAX_OUTSTANDING, 4: owner FIFO depth, a power of two, 1..16; sets the maximum number of requests in flight at the unit.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; **one clock; reset is synchronous and active-low**.
- req[NUM_REQ]  cfu_interface.slave  —  requester-facing ports: req_valid/req_ready/req_id/rs1/rs2 in; resp_valid/resp_ready/resp_id/resp_status/resp_data back.
- unit  cfu_interface.master  —  port to the shared unit.

## Operation
- Arbitration:
  - Combinational round-robin over req[i].req_valid, starting at rr_ptr.
  - Winner w is the first valid index at or after rr_ptr, with wrap-around.
- Forwarding:
  - unit.req_valid = any req_valid & !fifo_full & rst.
  - unit.req_id/rs1/rs2 come from req[w].
  - req[w].req_ready = unit.req_ready & !fifo_full & rst; every other req_ready is 0.
- Accept:
  - An accept occurs when unit.req_valid & unit.req_ready.
  - On accept, push w into the owner FIFO and set rr_ptr <= (w+1) mod NUM_REQ.
  - If no accept occurs, rr_ptr holds.
- Response routing:
  - The unit returns responses in issue order.
  - Head owner h = FIFO head; valid only when the FIFO is not empty.
  - req[h].resp_valid = unit.resp_valid & !fifo_empty; all other resp_valid are 0.
  - resp_id, resp_status and resp_data are broadcast to all ports; consumers qualify them with resp_valid.
  - unit.resp_ready = req[h].resp_ready & !fifo_empty.
- Pop: pop the FIFO when unit.resp_valid & unit.resp_ready.
- Boundary conditions:
  - Full: no accept, even if a pop occurs in the same cycle. There is no bypass, so no combinational path from resp_ready to req_ready.
  - Empty: unit.resp_valid is ignored, resp_ready is 0, and no pop occurs.
  - Push and pop in the same cycle (not full): the count is unchanged; head and tail pointers each advance by one, wrapping modulo MAX_OUTSTANDING.
  - A single requester asserting continuously is granted on every cycle the unit is ready.
- Reset, including mid-operation:
  - rr_ptr = 0; FIFO empty (count 0, pointers 0).
  - All req_ready, resp_valid, unit.req_valid and unit.resp_ready are 0 while rst = 0.
  - In-flight unit responses are lost, so the unit must be reset in the same cycle.

## Timing
- Zero added latency: request and response paths through the arbiter are combinational.
- Owner FIFO and rr_ptr are registered; a grant affects rr_ptr from the next cycle.
- End-to-end latency equals the unit latency; for a one-cycle registered unit, the response is visible at cycle t+1 after an accept at cycle t.
- Throughput is one request per cycle, limited by unit.req_ready and FIFO occupancy.
- Handshake rules:
  - A requester must hold req_valid and its payload until req_ready.
  - The arbiter never retracts a grant within a cycle.

## Configuration
- CFU_ARBITER_PERF_EN defined:
  - Adds output ports grant_count[NUM_REQ] (32-bit each) and full_stall_count (32-bit).
  - grant_count[i] increments on each accept with w = i.
  - full_stall_count increments on each cycle where any req_valid & fifo_full.
  - All counters reset to 0 and wrap modulo 2^32.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package cfu_arb_pkg holds:
  - localparam OWNER_W = $clog2(NUM_REQ) computation helper;
  - typedef owner_t;
  - round-robin next-index function rr_next(ptr, valid_vec).
- One sub-module, cfu_owner_fifo: synchronous FIFO of owner_t with push/pop/full/empty, parameter DEPTH = MAX_OUTSTANDING, same clk/rst (synchronous active-low).
- Top level holds the arbitration, muxing and, under the macro, the counters.

## Test plan
- Single requester:
  - Stimulus: req[0] issues rs1 = 0x00000001, id 3 to a sig0-style unit.
  - Required: req[0] gets resp_valid with resp_id 3 and resp_data = 0x02004000; req[1].resp_valid stays 0.
- Contention fairness:
  - Stimulus: NUM_REQ = 2, both requesters valid every cycle, unit always ready.
  - Required: grants alternate 0,1,0,1 starting from 0 after reset; 8 accepts yield 4 per requester.
- Full FIFO:
  - Stimulus: MAX_OUTSTANDING = 2, unit holds resp_valid = 0.
  - Required: after 2 accepts, all req_ready = 0; a pop in the same cycle as a pending request does not admit it until the next cycle.
- Response routing order:
  - Stimulus: issue from req[1], req[0], req[1].
  - Required: responses arrive on req[1], req[0], req[1]; if req[0] holds resp_ready = 0 for 3 cycles, unit.resp_ready = 0 for those cycles.
- Reset mid-operation:
  - Stimulus: 3 outstanding requests, then rst = 0 for one cycle.
  - Required: the next cycle has FIFO empty, rr_ptr = 0 and all valid/ready outputs 0; a later unit.resp_valid is ignored until a new accept.
- PERF_EN:
  - Stimulus: run the contention scenario for 10 accepts, then fill the FIFO with 5 blocked cycles.
  - Required: grant_count = {5,5} and full_stall_count = 5.

Source files
------------

// File: rtl/cfu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cfu_arb_pkg
// Shared types and helpers for the CFU round-robin arbiter.
//   MAX_REQ      : largest supported number of requester ports
//   OWNER_W      : width of an owner index (sized for MAX_REQ)
//   owner_t      : requester index stored in the owner FIFO
//   ID_W/DATA_W/STATUS_W : cfu_interface field widths
//   rr_next()    : first valid index at or after a pointer, with wrap-around
// -----------------------------------------------------------------------------
package cfu_arb_pkg;

   localparam int MAX_REQ  = 8;
   localparam int ID_W     = 8;
   localparam int DATA_W   = 32;
   localparam int STATUS_W = 2;

   function automatic int owner_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int OWNER_W = owner_width(MAX_REQ);

   typedef logic [OWNER_W-1:0] owner_t;

   // Scans num_req candidates starting at ptr. When nothing is valid the
   // pointer itself is returned so the grant index stays stable.
   function automatic owner_t rr_next(input owner_t             ptr,
                                      input logic [MAX_REQ-1:0] valid_vec,
                                      input logic [3:0]         num_req);
      logic [3:0] idx;
      owner_t     res;
      logic       found;
      res   = ptr;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = {1'b0, ptr} + 4'(k);
         if (idx >= num_req) begin
            idx = idx - num_req;
         end
         if (!found && (4'(k) < num_req) && valid_vec[idx[OWNER_W-1:0]]) begin
            res   = idx[OWNER_W-1:0];
            found = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/cfu_arbiter_if.sv
// -----------------------------------------------------------------------------
// cfu_interface
// Request/response channel between an issuer and a custom-function unit.
//   req_valid/req_ready/req_id/rs1/rs2        : request handshake + payload
//   resp_valid/resp_ready/resp_id/resp_status/resp_data : response handshake
//   master : issuer side (drives requests, accepts responses)
//   slave  : unit side (accepts requests, drives responses)
// -----------------------------------------------------------------------------
interface cfu_interface;
   import cfu_arb_pkg::*;

   logic                req_valid;
   logic                req_ready;
   logic [ID_W-1:0]     req_id;
   logic [DATA_W-1:0]   rs1;
   logic [DATA_W-1:0]   rs2;
   logic                resp_valid;
   logic                resp_ready;
   logic [ID_W-1:0]     resp_id;
   logic [STATUS_W-1:0] resp_status;
   logic [DATA_W-1:0]   resp_data;

   modport master (
      output req_valid, req_id, rs1, rs2, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_status, resp_data
   );

   modport slave (
      input  req_valid, req_id, rs1, rs2, resp_ready,
      output req_ready, resp_valid, resp_id, resp_status, resp_data
   );

endinterface

// File: rtl/cfu_arbiter_owner_fifo.sv
// -----------------------------------------------------------------------------
// cfu_owner_fifo
// In-order FIFO of requester indices, one entry per request in flight.
//   clk, rst    : clock, synchronous active-low reset (empties the FIFO)
//   push        : write push_owner at the tail (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   head_owner  : current head entry, read combinationally
//   full, empty : occupancy flags, derived from the registered count
// -----------------------------------------------------------------------------
module cfu_owner_fifo
   import cfu_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  owner_t push_owner,
   input  logic   pop,
   output owner_t head_owner,
   output logic   full,
   output logic   empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   owner_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // The head must be visible in the same cycle the response arrives, so
   // the storage is read asynchronously; it is only a few bits deep.
   assign head_owner = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while count_q says valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_owner;
      end
   end

endmodule

// File: rtl/cfu_arbiter.sv
// -----------------------------------------------------------------------------
// cfu_arbiter
// Round-robin arbiter sharing one custom-function unit among NUM_REQ
// requesters. Requests are forwarded combinationally; an owner FIFO remembers
// the issuer of each outstanding request so in-order responses are routed back.
//   clk, rst   : clock, synchronous active-low reset
//   req[i]     : requester-facing cfu_interface ports (slave side)
//   unit       : shared unit port (master side)
// Optional feature macro CFU_ARBITER_PERF_EN adds:
//   grant_count[i]   : accepts granted to requester i (32-bit, wraps)
//   full_stall_count : cycles with a pending request blocked by a full FIFO
// -----------------------------------------------------------------------------
module cfu_arbiter
   import cfu_arb_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic         clk,
   input  logic         rst,
   cfu_interface.slave  req [NUM_REQ],
   cfu_interface.master unit
`ifdef CFU_ARBITER_PERF_EN
   ,
   output logic [31:0]  grant_count [NUM_REQ],
   output logic [31:0]  full_stall_count
`endif
);

   logic [MAX_REQ-1:0] valid_vec;
   logic [MAX_REQ-1:0] resp_ready_vec;
   logic [ID_W-1:0]    id_arr  [MAX_REQ];
   logic [DATA_W-1:0]  rs1_arr [MAX_REQ];
   logic [DATA_W-1:0]  rs2_arr [MAX_REQ];

   owner_t rr_ptr_q, rr_ptr_d;
   owner_t win;
   owner_t head;
   logic   any_valid;
   logic   fifo_full;
   logic   fifo_empty;
   logic   grant_ok;
   logic   accept;
   logic   resp_ok;
   logic   pop;

   // Interface arrays only allow constant indices, so every port is flattened
   // into plain vectors/arrays padded to MAX_REQ; the muxes then index those.
   genvar gi;
   generate
      for (gi = 0; gi < MAX_REQ; gi++) begin : g_port
         if (gi < NUM_REQ) begin : g_used
            assign valid_vec[gi]      = req[gi].req_valid;
            assign resp_ready_vec[gi] = req[gi].resp_ready;
            assign id_arr[gi]         = req[gi].req_id;
            assign rs1_arr[gi]        = req[gi].rs1;
            assign rs2_arr[gi]        = req[gi].rs2;

            assign req[gi].req_ready   = grant_ok && (win == owner_t'(gi));
            assign req[gi].resp_valid  = resp_ok && (head == owner_t'(gi));
            assign req[gi].resp_id     = unit.resp_id;
            assign req[gi].resp_status = unit.resp_status;
            assign req[gi].resp_data   = unit.resp_data;
         end else begin : g_unused
            assign valid_vec[gi]      = 1'b0;
            assign resp_ready_vec[gi] = 1'b0;
            assign id_arr[gi]         = '0;
            assign rs1_arr[gi]        = '0;
            assign rs2_arr[gi]        = '0;
         end
      end
   endgenerate

   assign any_valid = |valid_vec;
   assign win       = rr_next(rr_ptr_q, valid_vec, 4'(NUM_REQ));

   // Full blocks admission even when a pop happens this cycle: fifo_full is
   // registered, which keeps resp_ready out of the req_ready cone.
   assign unit.req_valid = any_valid & ~fifo_full & rst;
   assign unit.req_id    = id_arr[win];
   assign unit.rs1       = rs1_arr[win];
   assign unit.rs2       = rs2_arr[win];
   assign grant_ok       = unit.req_ready & ~fifo_full & rst;
   assign accept         = unit.req_valid & unit.req_ready;

   // Responses with no recorded owner are neither routed nor consumed.
   assign resp_ok         = unit.resp_valid & ~fifo_empty & rst;
   assign unit.resp_ready = resp_ready_vec[head] & ~fifo_empty & rst;
   assign pop             = unit.resp_valid & unit.resp_ready;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (win == owner_t'(NUM_REQ - 1)) ? '0 : win + owner_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   cfu_owner_fifo #(
      .DEPTH(MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (accept),
      .push_owner (win),
      .pop        (pop),
      .head_owner (head),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

`ifdef CFU_ARBITER_PERF_EN
   logic [31:0] grant_count_q [NUM_REQ];
   logic [31:0] grant_count_d [NUM_REQ];
   logic [31:0] full_stall_count_q, full_stall_count_d;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_count_d[i] = grant_count_q[i];
         if (accept && (win == owner_t'(i))) begin
            grant_count_d[i] = grant_count_q[i] + 32'd1;
         end
      end
      full_stall_count_d = full_stall_count_q;
      if (any_valid && fifo_full) begin
         full_stall_count_d = full_stall_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            grant_count_q[i] <= '0;
         end
         full_stall_count_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            grant_count_q[i] <= grant_count_d[i];
         end
         full_stall_count_q <= full_stall_count_d;
      end
   end

   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_perf
         assign grant_count[gi] = grant_count_q[gi];
      end
   endgenerate
   assign full_stall_count = full_stall_count_q;
`endif

endmodule

// File: tb/tb_cfu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cfu_arbiter
// Bench for cfu_arbiter with two requesters and a four-deep owner FIFO in
// front of a one-cycle registered SHA-256 sigma-0 unit model. Expected
// responses are queued when a request is expected to be accepted and are
// compared when a requester port completes a response handshake.
// Optional feature macro CFU_ARBITER_PERF_EN enables the counter checks.
// -----------------------------------------------------------------------------
module tb_cfu_arbiter;
   import cfu_arb_pkg::*;

   localparam int NREQ  = 2;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cfu_interface req_if [NREQ] ();
   cfu_interface unit_if ();

`ifdef CFU_ARBITER_PERF_EN
   logic [31:0] grant_count [NREQ];
   logic [31:0] full_stall_count;
`endif

   cfu_arbiter #(
      .NUM_REQ         (NREQ),
      .MAX_OUTSTANDING (DEPTH)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req_if),
      .unit (unit_if)
`ifdef CFU_ARBITER_PERF_EN
      ,
      .grant_count      (grant_count),
      .full_stall_count (full_stall_count)
`endif
   );

   int tests = 0;
   int fails = 0;

   // requester drive
   logic [1:0]      v        = 2'b00;
   logic [1:0]      resp_rdy = 2'b11;
   logic [ID_W-1:0] drv_id  [NREQ];
   logic [31:0]     drv_rs1 [NREQ];
   int              pl_seq   = 0;

   assign req_if[0].req_valid  = v[0];
   assign req_if[1].req_valid  = v[1];
   assign req_if[0].resp_ready = resp_rdy[0];
   assign req_if[1].resp_ready = resp_rdy[1];
   assign req_if[0].req_id     = drv_id[0];
   assign req_if[1].req_id     = drv_id[1];
   assign req_if[0].rs1        = drv_rs1[0];
   assign req_if[1].rs1        = drv_rs1[1];
   assign req_if[0].rs2        = ~drv_rs1[0];
   assign req_if[1].rs2        = ~drv_rs1[1];

   logic [1:0] rdy_vec;
   logic [1:0] rv_vec;
   assign rdy_vec = {req_if[1].req_ready, req_if[0].req_ready};
   assign rv_vec  = {req_if[1].resp_valid, req_if[0].resp_valid};

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   // one-cycle registered sigma-0 unit with a response queue
   logic            unit_ready   = 1'b1;
   logic            unit_resp_en = 1'b1;
   logic            fake_resp    = 1'b0;
   logic [ID_W-1:0] uq_id   [16];
   logic [31:0]     uq_data [16];
   logic [3:0]      uq_head, uq_tail;
   int              uq_cnt;

   assign unit_if.req_ready   = unit_ready;
   assign unit_if.resp_valid  = (unit_resp_en && (uq_cnt != 0)) || fake_resp;
   assign unit_if.resp_id     = uq_id[uq_head];
   assign unit_if.resp_data   = uq_data[uq_head];
   assign unit_if.resp_status = '0;

   always @(posedge clk) begin
      if (!rst) begin
         uq_head <= '0;
         uq_tail <= '0;
         uq_cnt  <= 0;
      end else begin
         if (unit_if.req_valid && unit_if.req_ready) begin
            uq_id[uq_tail]   <= unit_if.req_id;
            uq_data[uq_tail] <= sig0(unit_if.rs1);
            uq_tail          <= uq_tail + 4'd1;
         end
         if (unit_if.resp_valid && unit_if.resp_ready && (uq_cnt != 0)) begin
            uq_head <= uq_head + 4'd1;
         end
         uq_cnt <= uq_cnt
                   + ((unit_if.req_valid && unit_if.req_ready) ? 1 : 0)
                   - ((unit_if.resp_valid && unit_if.resp_ready && (uq_cnt != 0)) ? 1 : 0);
      end
   end

   // scoreboard
   typedef struct {
      int              port;
      logic [ID_W-1:0] id;
      logic [31:0]     data;
   } exp_t;
   exp_t sb [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic expect_resp(input int p, input logic [31:0] data);
      exp_t e;
      e.port = p;
      e.id   = drv_id[p];
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic new_payload(input int p);
      pl_seq++;
      drv_id[p]  = ID_W'(pl_seq);
      drv_rs1[p] = $urandom;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (rv_vec == 2'b11) begin
            check("resp_valid_onehot", {30'd0, rv_vec}, 32'd1);
         end
         for (int p = 0; p < NREQ; p++) begin
            if (rv_vec[p] && resp_rdy[p]) begin
               if (sb.size() == 0) begin
                  check("resp_unexpected_port", p, 32'hFFFF_FFFF);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  $display("[TB] resp port=%0d id=0x%02h data=0x%08h", p,
                           unit_if.resp_id, unit_if.resp_data);
                  check("resp_port", p, e.port);
                  check("resp_id", {24'd0, unit_if.resp_id}, {24'd0, e.id});
                  check("resp_data", unit_if.resp_data, e.data);
               end
            end
         end
      end
   end

   task automatic drain();
      v            = 2'b00;
      unit_ready   = 1'b1;
      unit_resp_en = 1'b1;
      resp_rdy     = 2'b11;
      for (int i = 0; i < 40 && (sb.size() != 0 || uq_cnt != 0); i++) begin
         cyc();
      end
      check("drain_empty", sb.size(), 0);
      sb.delete();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      sb.delete();
   endtask

   typedef struct {
      logic [1:0] v;
      logic       ur;
      logic [1:0] exp_rdy;
      logic       exp_uv;
      int         exp_win;   // -1: no accept expected
   } vec_t;
   vec_t tbl [10];

   initial begin
      int cnt [NREQ];
      int g;

      tbl[0] = '{2'b01, 1'b1, 2'b01, 1'b1,  0};
      tbl[1] = '{2'b01, 1'b1, 2'b01, 1'b1,  0};
      tbl[2] = '{2'b11, 1'b1, 2'b10, 1'b1,  1};
      tbl[3] = '{2'b11, 1'b1, 2'b01, 1'b1,  0};
      tbl[4] = '{2'b11, 1'b1, 2'b10, 1'b1,  1};
      tbl[5] = '{2'b11, 1'b0, 2'b00, 1'b1, -1};
      tbl[6] = '{2'b10, 1'b1, 2'b10, 1'b1,  1};
      tbl[7] = '{2'b00, 1'b1, 2'b01, 1'b0, -1};
      tbl[8] = '{2'b10, 1'b1, 2'b10, 1'b1,  1};
      tbl[9] = '{2'b11, 1'b1, 2'b01, 1'b1,  0};

      for (int p = 0; p < NREQ; p++) new_payload(p);
      cyc();
      cyc();

      // outputs gated while reset is held, even with requests pending
      v = 2'b11;
      #1;
      check("rst_req_ready", {30'd0, rdy_vec}, 32'd0);
      check("rst_unit_req_valid", unit_if.req_valid, 1'b0);
      check("rst_unit_resp_ready", unit_if.resp_ready, 1'b0);
      check("rst_resp_valid", {30'd0, rv_vec}, 32'd0);
      cyc();
      rst = 1'b1;
      v   = 2'b00;
      #1;
      check("idle_unit_req_valid", unit_if.req_valid, 1'b0);
      check("idle_unit_resp_ready", unit_if.resp_ready, 1'b0);
      check("idle_ptr_zero_rdy", {30'd0, rdy_vec}, 32'd1);
`ifdef CFU_ARBITER_PERF_EN
      check("perf_rst_grant0", grant_count[0], 32'd0);
      check("perf_rst_grant1", grant_count[1], 32'd0);
      check("perf_rst_stall", full_stall_count, 32'd0);
`endif

      // single requester, sigma-0 of 1
      drv_id[0]  = 8'd3;
      drv_rs1[0] = 32'h0000_0001;
      v          = 2'b01;
      #1;
      check("single_rdy", {30'd0, rdy_vec}, 32'd1);
      check("single_fwd_id", {24'd0, unit_if.req_id}, 32'd3);
      check("single_fwd_rs1", unit_if.rs1, 32'h0000_0001);
      expect_resp(0, 32'h0200_4000);
      $display("[TB] issue port=0 id=0x03 rs1=0x00000001");
      cyc();
      v = 2'b00;
      #1;
      check("single_resp_valid", {30'd0, rv_vec}, 32'd1);
      check("single_resp_id", {24'd0, req_if[0].resp_id}, 32'd3);
      check("single_resp_data", req_if[0].resp_data, 32'h0200_4000);
      cyc();
      new_payload(0);
      drain();

      // contention fairness from reset
      do_reset();
      cnt[0] = 0;
      cnt[1] = 0;
      v = 2'b11;
      for (int k = 0; k < 8; k++) begin
         #1;
         g = (rdy_vec == 2'b01) ? 0 : (rdy_vec == 2'b10) ? 1 : -1;
         check("fair_grant", g, k % 2);
         if (g >= 0) cnt[g]++;
         expect_resp(k % 2, sig0(drv_rs1[k % 2]));
         $display("[TB] fair accept %0d grant=%0d", k, g);
         cyc();
         new_payload(k % 2);
      end
      check("fair_count0", cnt[0], 4);
      check("fair_count1", cnt[1], 4);
      drain();

      // table-driven arbitration vectors (rr_ptr is 0 here)
      for (int r = 0; r < 10; r++) begin
         v          = tbl[r].v;
         unit_ready = tbl[r].ur;
         #1;
         check("tbl_rdy", {30'd0, rdy_vec}, {30'd0, tbl[r].exp_rdy});
         check("tbl_unit_valid", unit_if.req_valid, tbl[r].exp_uv);
         if (tbl[r].exp_win >= 0) begin
            check("tbl_fwd_id", {24'd0, unit_if.req_id}, {24'd0, drv_id[tbl[r].exp_win]});
            expect_resp(tbl[r].exp_win, sig0(drv_rs1[tbl[r].exp_win]));
         end
         $display("[TB] vec %0d v=%b ur=%b rdy=%b", r, tbl[r].v, tbl[r].ur, rdy_vec);
         cyc();
         if (tbl[r].exp_win >= 0) new_payload(tbl[r].exp_win);
      end
      drain();

      // full FIFO: unit withholds responses (rr_ptr is 1 here)
      unit_resp_en = 1'b0;
      v = 2'b01;
      for (int k = 0; k < DEPTH; k++) begin
         #1;
         check("full_fill_rdy", {30'd0, rdy_vec}, 32'd1);
         expect_resp(0, sig0(drv_rs1[0]));
         $display("[TB] fill accept %0d", k);
         cyc();
         new_payload(0);
      end
      v = 2'b11;
      #1;
      check("full_rdy", {30'd0, rdy_vec}, 32'd0);
      check("full_unit_valid", unit_if.req_valid, 1'b0);
      cyc();
      unit_resp_en = 1'b1;
      #1;
      check("full_pop_resp_ready", unit_if.resp_ready, 1'b1);
      check("full_pop_cycle_rdy", {30'd0, rdy_vec}, 32'd0);
      cyc();
      #1;
      check("full_admit_next", {30'd0, rdy_vec}, 32'd2);
      expect_resp(1, sig0(drv_rs1[1]));
      cyc();
      new_payload(1);
      drain();

      // response routing order 1,0,1 (rr_ptr is 0 here)
      unit_resp_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         g = (k == 1) ? 0 : 1;
         v = (g == 0) ? 2'b01 : 2'b10;
         #1;
         check("route_issue_rdy", {30'd0, rdy_vec}, (g == 0) ? 32'd1 : 32'd2);
         expect_resp(g, sig0(drv_rs1[g]));
         cyc();
         new_payload(g);
      end
      v            = 2'b00;
      resp_rdy     = 2'b10;
      unit_resp_en = 1'b1;
      #1;
      check("route_first_port1", {30'd0, rv_vec}, 32'd2);
      cyc();
      for (int k = 0; k < 3; k++) begin
         #1;
         check("route_hold_valid0", {30'd0, rv_vec}, 32'd1);
         check("route_hold_unit_ready", unit_if.resp_ready, 1'b0);
         cyc();
      end
      drain();

      // reset with three requests in flight
      unit_resp_en = 1'b0;
      v = 2'b01;
      for (int k = 0; k < 3; k++) begin
         cyc();
         new_payload(0);
      end
      rst = 1'b0;
      v   = 2'b11;
      #1;
      check("midrst_rdy", {30'd0, rdy_vec}, 32'd0);
      check("midrst_unit_valid", unit_if.req_valid, 1'b0);
      check("midrst_unit_resp_ready", unit_if.resp_ready, 1'b0);
      cyc();
      sb.delete();
      rst       = 1'b1;
      v         = 2'b00;
      fake_resp = 1'b1;
      #1;
      check("postrst_resp_valid", {30'd0, rv_vec}, 32'd0);
      check("postrst_resp_ready", unit_if.resp_ready, 1'b0);
      cyc();
      fake_resp = 1'b0;
      v = 2'b11;
      #1;
      check("postrst_ptr_zero", {30'd0, rdy_vec}, 32'd1);
      expect_resp(0, sig0(drv_rs1[0]));
      cyc();
      new_payload(0);
      drain();

`ifdef CFU_ARBITER_PERF_EN
      do_reset();
      v = 2'b11;
      for (int k = 0; k < 10; k++) begin
         #1;
         check("perf_fair_rdy", {30'd0, rdy_vec}, (k % 2 == 0) ? 32'd1 : 32'd2);
         expect_resp(k % 2, sig0(drv_rs1[k % 2]));
         cyc();
         new_payload(k % 2);
      end
      check("perf_grant0_10", grant_count[0], 32'd5);
      check("perf_grant1_10", grant_count[1], 32'd5);
      drain();
      unit_resp_en = 1'b0;
      v = 2'b11;
      for (int k = 0; k < DEPTH; k++) begin
         expect_resp(k % 2, sig0(drv_rs1[k % 2]));
         cyc();
         new_payload(k % 2);
      end
      for (int k = 0; k < 5; k++) cyc();
      check("perf_stall", full_stall_count, 32'd5);
      check("perf_grant0_fill", grant_count[0], 32'd7);
      check("perf_grant1_fill", grant_count[1], 32'd7);
      drain();
`endif

      check("sb_empty_end", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
